// File: rtl/demux2_64bit_stream_if.sv
// Handshake bundle for the two-way stream demultiplexer: one input stream,
// two output streams. The slave modport is the demux; master is its environment.
interface demux2_64bit_stream_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             s;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;

  modport slave (
    input  in_valid, in_data, s, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  modport master (
    output in_valid, in_data, s, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
  );
endinterface

// File: rtl/demux2_64bit_stream.sv
// Two-way stream demultiplexer. Each output channel is a one-entry buffer
// (EMPTY/FULL). The select s picks the destination of the accepted word;
// backpressure comes only from the selected channel. Each channel also
// counts the words it has accepted (wrapping counter).
module demux2_64bit_stream #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  demux2_64bit_stream_if.slave   bus,
  output logic [CNT_W-1:0]       cnt0,
  output logic [CNT_W-1:0]       cnt1
);

  logic [1:0]       out_ready;
  logic [1:0]       valid;
  logic [WIDTH-1:0] data  [2];
  logic [CNT_W-1:0] count [2];
  logic             sel_ready;
  logic             accept;

  assign out_ready = {bus.out1_ready, bus.out0_ready};

  // A channel can take a word if it is empty or is being drained this cycle.
  // Held at 0 during reset so nothing can be accepted.
  assign sel_ready    = bus.s ? (~valid[1] | out_ready[1]) : (~valid[0] | out_ready[0]);
  assign bus.in_ready = rst_n & sel_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_ch
      localparam logic CH = 1'(gi);

      logic             valid_reg;
      logic [WIDTH-1:0] data_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             load;
      logic             drain;

      // s is only meaningful together with an acceptance.
      assign load  = accept & (bus.s == CH);
      assign drain = valid_reg & out_ready[gi];

      // One-entry buffer: a load wins over a drain so a simultaneous
      // drain+load keeps the channel full with the new word.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
          cnt_reg   <= '0;
        end else if (load) begin
          valid_reg <= 1'b1;
          data_reg  <= bus.in_data;
          cnt_reg   <= cnt_reg + 1'b1;
        end else if (drain) begin
          valid_reg <= 1'b0;
        end
      end

      assign valid[gi] = valid_reg;
      assign data[gi]  = data_reg;
      assign count[gi] = cnt_reg;
    end
  endgenerate

  assign bus.out0_valid = valid[0];
  assign bus.out0_data  = data[0];
  assign bus.out1_valid = valid[1];
  assign bus.out1_data  = data[1];
  assign cnt0           = count[0];
  assign cnt1           = count[1];

endmodule

// File: tb/tb_demux2_64bit_stream.sv
// Bench for demux2_64bit_stream: directed vector table, randomized traffic
// against a reference model, counter wrap and mid-operation reset.
module tb_demux2_64bit_stream;
  localparam int WIDTH = 64;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CNT_W-1:0] cnt0, cnt1;

  demux2_64bit_stream_if #(.WIDTH(WIDTH)) bus ();

  demux2_64bit_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .cnt0 (cnt0),
    .cnt1 (cnt1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: each channel holds at most one word; counts are plain
  // integers reduced modulo 2^CNT_W when compared.
  bit          m_full [2];
  logic [63:0] m_word [2];
  int          m_cnt  [2];

  typedef struct {
    logic        iv;
    logic        s;
    logic [63:0] d;
    logic        r0;
    logic        r1;
    logic        rdy;
    logic        v0;
    logic [63:0] d0;
    logic        v1;
    logic [63:0] d1;
    logic [7:0]  c0;
    logic [7:0]  c1;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(logic iv, logic s, logic [63:0] d, logic r0, logic r1,
                              logic rdy, logic v0, logic [63:0] d0, logic v1,
                              logic [63:0] d1, logic [7:0] c0, logic [7:0] c1);
    vec_t v;
    v.iv = iv; v.s = s; v.d = d; v.r0 = r0; v.r1 = r1;
    v.rdy = rdy; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.c0 = c0; v.c1 = c1;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(logic iv, logic s, logic [63:0] d, logic r0, logic r1);
    bus.in_valid   = iv;
    bus.s          = s;
    bus.in_data    = d;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
  endtask

  task automatic chk_outputs(string tag, logic v0, logic [63:0] d0, logic v1,
                             logic [63:0] d1, logic [7:0] c0, logic [7:0] c1);
    chk({tag, " out0_valid"}, 64'(bus.out0_valid), 64'(v0));
    chk({tag, " out0_data"},  bus.out0_data, d0);
    chk({tag, " out1_valid"}, 64'(bus.out1_valid), 64'(v1));
    chk({tag, " out1_data"},  bus.out1_data, d1);
    chk({tag, " cnt0"},       64'(cnt0), 64'(c0));
    chk({tag, " cnt1"},       64'(cnt1), 64'(c1));
  endtask

  // Apply one table vector: check in_ready mid-cycle, outputs after the edge.
  task automatic apply_vec(int idx, vec_t v);
    drive(v.iv, v.s, v.d, v.r0, v.r1);
    #2;
    chk($sformatf("vec%0d in_ready", idx), 64'(bus.in_ready), 64'(v.rdy));
    @(posedge clk);
    #1;
    chk_outputs($sformatf("vec%0d", idx), v.v0, v.d0, v.v1, v.d1, v.c0, v.c1);
    $display("vec %0d: iv=%0b s=%0b d=%h r0=%0b r1=%0b -> rdy=%0b v0=%0b v1=%0b cnt0=%0d cnt1=%0d",
             idx, v.iv, v.s, v.d, v.r0, v.r1, bus.in_ready, bus.out0_valid,
             bus.out1_valid, cnt0, cnt1);
  endtask

  // Apply one cycle of stimulus and compare against the reference model.
  task automatic model_step(string tag, logic iv, logic s, logic [63:0] d,
                            logic r0, logic r1, bit verbose);
    bit rdy;
    bit taken;
    int ch;
    drive(iv, s, d, r0, r1);
    ch  = s ? 1 : 0;
    rdy = !m_full[ch] || (ch == 1 ? r1 : r0);
    #2;
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'(rdy));
    taken = iv && rdy;
    // Drains first, then the accepted word (if any) lands in its channel.
    if (m_full[0] && r0) m_full[0] = 0;
    if (m_full[1] && r1) m_full[1] = 0;
    if (taken) begin
      m_full[ch] = 1;
      m_word[ch] = d;
      m_cnt[ch]  = m_cnt[ch] + 1;
    end
    @(posedge clk);
    #1;
    chk_outputs(tag, m_full[0], m_word[0], m_full[1], m_word[1],
                8'(m_cnt[0] % 256), 8'(m_cnt[1] % 256));
    if (verbose && taken)
      $display("%s: word %h -> channel %0d (cnt0=%0d cnt1=%0d)", tag, d, ch, cnt0, cnt1);
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd0);
    chk_outputs(tag, 1'b0, 64'd0, 1'b0, 64'd0, 8'd0, 8'd0);
  endtask

  initial begin
    logic [63:0] ones;
    int c0_before;
    int c1_before;
    ones = '1;

    // Directed table, starting from the post-reset state.
    tbl[0]  = mk(1, 0, 64'h1,  0, 0,  1, 1, 64'h1, 0, 64'h0,  8'd1, 8'd0);
    tbl[1]  = mk(1, 1, 64'h2,  0, 0,  1, 1, 64'h1, 1, 64'h2,  8'd1, 8'd1);
    tbl[2]  = mk(0, 0, 64'h0,  0, 1,  0, 1, 64'h1, 0, 64'h2,  8'd1, 8'd1);
    tbl[3]  = mk(1, 0, 64'hAA, 0, 0,  0, 1, 64'h1, 0, 64'h2,  8'd1, 8'd1);
    tbl[4]  = mk(1, 1, 64'hBB, 0, 0,  1, 1, 64'h1, 1, 64'hBB, 8'd1, 8'd2);
    tbl[5]  = mk(0, 0, 64'h0,  1, 1,  1, 0, 64'h1, 0, 64'hBB, 8'd1, 8'd2);
    tbl[6]  = mk(1, 0, 64'h5,  1, 0,  1, 1, 64'h5, 0, 64'hBB, 8'd2, 8'd2);
    tbl[7]  = mk(1, 0, 64'h3,  1, 0,  1, 1, 64'h3, 0, 64'hBB, 8'd3, 8'd2);
    tbl[8]  = mk(1, 0, 64'h7,  1, 0,  1, 1, 64'h7, 0, 64'hBB, 8'd4, 8'd2);
    tbl[9]  = mk(1, 0, ones,   1, 0,  1, 1, ones,  0, 64'hBB, 8'd5, 8'd2);
    tbl[10] = mk(0, 0, 64'h0,  1, 0,  1, 0, ones,  0, 64'hBB, 8'd5, 8'd2);
    tbl[11] = mk(0, 1, 64'h77, 0, 0,  1, 0, ones,  0, 64'hBB, 8'd5, 8'd2);

    // Reset held with in_valid high: nothing accepted, everything zero.
    rst_n = 1'b0;
    drive(1, 0, 64'hDEAD_BEEF_0000_0001, 0, 0);
    #2;
    chk_reset_state("reset");
    @(posedge clk);
    #1;
    chk_reset_state("reset_after_edge");
    #2;
    rst_n = 1'b1;

    // First edge after release must already accept (vec0).
    for (int i = 0; i < 12; i++) apply_vec(i, tbl[i]);

    // Hand the table's final state to the model.
    m_full[0] = 0; m_word[0] = ones;   m_cnt[0] = 5;
    m_full[1] = 0; m_word[1] = 64'hBB; m_cnt[1] = 2;

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      model_step($sformatf("rand%0d", i), 1'($urandom_range(0, 3) != 0),
                 1'($urandom), {$urandom, $urandom},
                 1'($urandom), 1'($urandom_range(0, 2) != 0), 1'b1);
    end

    // 256 back-to-back acceptances into channel 1 wrap cnt1 to where it began.
    c0_before = int'(cnt0);
    c1_before = int'(cnt1);
    for (int i = 0; i < 256; i++)
      model_step($sformatf("wrap%0d", i), 1'b1, 1'b1, 64'(i), 1'b0, 1'b1, 1'b0);
    chk("wrap cnt1", 64'(cnt1), 64'(c1_before));
    chk("wrap cnt0", 64'(cnt0), 64'(c0_before));
    $display("wrap: 256 words to channel 1, cnt1=%0d cnt0=%0d", cnt1, cnt0);

    // Fill both channels, then pulse reset between edges.
    model_step("fill0", 1'b1, 1'b0, 64'h1111, 1'b0, 1'b0, 1'b1);
    model_step("fill1", 1'b1, 1'b1, 64'h2222, 1'b0, 1'b0, 1'b1);
    drive(1, 0, 64'h9999, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midreset");
    @(posedge clk);
    #1;
    chk_reset_state("midreset_after_edge");
    #2;
    rst_n = 1'b1;
    m_full[0] = 0; m_word[0] = '0; m_cnt[0] = 0;
    m_full[1] = 0; m_word[1] = '0; m_cnt[1] = 0;
    model_step("post_reset0", 1'b1, 1'b1, 64'h1234_5678, 1'b0, 1'b0, 1'b1);
    model_step("post_reset1", 1'b1, 1'b0, 64'hCAFE, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
